// File: rtl/vermicache_pkg.sv
// Types and width helpers for the vermicache direct-mapped cache.
// The optional statistics counters are built in when VERMICACHE_STATS_EN is defined.
package vermicache_pkg;

  typedef vermitypes_pkg::word_t word_t;

  localparam int ADDR_W    = 32;
  localparam int MAX_TAG_W = ADDR_W - 2 - 1;  // widest tag, reached with LINES = 2

  typedef enum logic [1:0] {
    IDLE,
    FILL,
    WRITE,
    BYPASS
  } state_t;

  // One cache line as seen on the lookup port; tag is zero-extended to MAX_TAG_W.
  typedef struct packed {
    logic                 valid;
    logic [MAX_TAG_W-1:0] tag;
    word_t                data;
  } cache_line_t;

  function automatic int idx_w(input int lines);
    return $clog2(lines);
  endfunction

  function automatic int tag_w(input int lines);
    return ADDR_W - 2 - $clog2(lines);
  endfunction

endpackage

// File: rtl/vermitypes_pkg.sv
// Shared machine-word types for the Vermi core family.
package vermitypes_pkg;

  typedef logic [31:0] word_t;

endpackage

// File: rtl/vermicache_if.sv
// Vermibus request/response bundle. The core side of the cache uses the slave
// modport, the memory side uses the master modport.
interface vermicache_if;
  import vermitypes_pkg::*;

  logic       valid;
  logic       ready;
  word_t      address;
  logic [3:0] wstrobe;
  word_t      wdata;
  word_t      rdata;
  logic       irq;

  modport master (
    output valid, address, wstrobe, wdata,
    input  ready, rdata, irq
  );

  modport slave (
    input  valid, address, wstrobe, wdata,
    output ready, rdata, irq
  );

endinterface

// File: rtl/vermicache_store.sv
// Line storage for vermicache: valid bits, tags and data words.
// Asynchronous lookup read; synchronous fill, byte-merged store and global valid clear.
module vermicache_store
  import vermicache_pkg::*;
#(
  parameter  int LINES = 64,
  localparam int IDX_W = idx_w(LINES),
  localparam int TAG_W = tag_w(LINES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [IDX_W-1:0]  rd_idx,
  output cache_line_t       rd_line,
  input  logic [IDX_W-1:0]  wr_idx,
  input  logic [TAG_W-1:0]  wr_tag,
  input  word_t             wr_data,
  input  logic [3:0]        st_strb,
  input  logic              fill_en,
  input  logic              st_en,
  input  logic              clr
);

  logic [LINES-1:0] valid_q;
  logic [TAG_W-1:0] tag_q  [LINES];
  word_t            data_q [LINES];

  // Valid bits: clear wipes everything, but a fill on the same edge keeps its own line.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
    end else begin
      if (clr)     valid_q         <= '0;
      if (fill_en) valid_q[wr_idx] <= 1'b1;
    end
  end

  // Tag/data arrays: whole-line replace on fill, strobed byte merge on a store hit.
  always_ff @(posedge clk) begin
    if (fill_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end else if (st_en) begin
      for (int b = 0; b < 4; b++) begin
        if (st_strb[b]) data_q[wr_idx][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // Lookup port: zero-extend the stored tag into the common line format.
  always_comb begin
    rd_line       = '0;
    rd_line.valid = valid_q[rd_idx];
    rd_line.tag   = MAX_TAG_W'(tag_q[rd_idx]);
    rd_line.data  = data_q[rd_idx];
  end

endmodule

// File: rtl/vermicache.sv
// vermicache: direct-mapped, write-through, no-write-allocate, one-word-line cache
// between the core's Vermibus port (s) and memory (m). Read hits complete with zero
// wait states; misses, stores and uncached reads take one decision cycle plus the
// memory latency. Defining VERMICACHE_STATS_EN adds hit_count/miss_count outputs.
module vermicache
  import vermicache_pkg::*;
#(
  parameter  int          LINES         = 64,
  parameter  logic [31:0] UNCACHED_BASE = 32'h8000_0000,
  localparam int          IDX_W         = idx_w(LINES),
  localparam int          TAG_W         = tag_w(LINES)
) (
  input  logic          clk,
  input  logic          reset,
  vermicache_if.slave   s,
  vermicache_if.master  m,
  input  logic          invalidate
`ifdef VERMICACHE_STATS_EN
  ,
  output logic [31:0]   hit_count,
  output logic [31:0]   miss_count
`endif
);

  state_t      state_q, state_d;
  word_t       req_addr;
  logic [3:0]  req_strb;
  word_t       req_wdata;
  logic        req_en;

  word_t       lk_addr;
  logic [IDX_W-1:0] lk_idx;
  logic [TAG_W-1:0] lk_tag;
  logic        cacheable;
  logic        hit;
  cache_line_t line;

  logic        fill_en;
  logic        st_en;
  logic        hit_done;

  // In IDLE the live request is looked up; afterwards the latched one is.
  assign lk_addr   = (state_q == IDLE) ? s.address : req_addr;
  assign lk_idx    = lk_addr[2 +: IDX_W];
  assign lk_tag    = lk_addr[31 -: TAG_W];
  assign cacheable = (lk_addr < UNCACHED_BASE);
  assign hit       = line.valid && (line.tag == MAX_TAG_W'(lk_tag)) && cacheable;

  assign m.address = req_addr;
  assign m.wdata   = req_wdata;
  assign s.irq     = m.irq;

  vermicache_store #(.LINES(LINES)) u_store (
    .clk     (clk),
    .reset   (reset),
    .rd_idx  (lk_idx),
    .rd_line (line),
    .wr_idx  (lk_idx),
    .wr_tag  (lk_tag),
    .wr_data (fill_en ? m.rdata : req_wdata),
    .st_strb (req_strb),
    .fill_en (fill_en),
    .st_en   (st_en),
    .clr     (invalidate)
  );

  // FSM state register; reset abandons any memory access in flight.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Request latch, loaded when IDLE hands a request to memory.
  always_ff @(posedge clk) begin
    if (req_en) begin
      req_addr  <= s.address;
      req_strb  <= s.wstrobe;
      req_wdata <= s.wdata;
    end
  end

  // Next state, handshake muxing and array write enables.
  always_comb begin
    state_d   = state_q;
    req_en    = 1'b0;
    s.ready   = 1'b0;
    s.rdata   = '0;
    m.valid   = 1'b0;
    m.wstrobe = '0;
    fill_en   = 1'b0;
    st_en     = 1'b0;
    hit_done  = 1'b0;
    case (state_q)
      IDLE: begin
        // invalidate blocks new requests for one cycle; the core simply retries.
        if (s.valid && !invalidate) begin
          if (s.wstrobe != 4'b0000) begin
            req_en  = 1'b1;
            state_d = WRITE;
          end else if (!cacheable) begin
            req_en  = 1'b1;
            state_d = BYPASS;
          end else if (hit) begin
            s.ready  = 1'b1;
            s.rdata  = line.data;
            hit_done = 1'b1;
          end else begin
            req_en  = 1'b1;
            state_d = FILL;
          end
        end
      end
      FILL: begin
        m.valid = 1'b1;
        s.ready = m.ready;
        s.rdata = m.rdata;
        if (m.ready) begin
          fill_en = 1'b1;
          state_d = IDLE;
        end
      end
      WRITE: begin
        m.valid   = 1'b1;
        m.wstrobe = req_strb;
        s.ready   = m.ready;
        s.rdata   = m.rdata;
        if (m.ready) begin
          st_en   = hit;
          state_d = IDLE;
        end
      end
      BYPASS: begin
        m.valid = 1'b1;
        s.ready = m.ready;
        s.rdata = m.rdata;
        if (m.ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef VERMICACHE_STATS_EN
  // Hit/miss statistics, wrapping modulo 2^32.
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit_done) hit_count  <= hit_count + 32'd1;
      if (fill_en)  miss_count <= miss_count + 32'd1;
    end
  end
`endif

endmodule
